// File: rtl/adapter_pkg.sv
// +----------------------------------------------------------------------------+
// | adapter_pkg                                                                |
// | Frame slice offsets, feature geometry and vector type for the data adapter.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package adapter_pkg;

   localparam int FRAME_W   = 3840;
   localparam int FEAT_W    = 16;
   localparam int NUM_FEAT  = 16;
   localparam int CAM_GROUP = 12;
   localparam int SUM_W     = 20;

   localparam int CAM_LSB   = 0;
   localparam int LIDAR_LSB = 3072;
   localparam int RADAR_LSB = 3584;
   localparam int IMU_LSB   = 3712;
   localparam int TS_LSB    = 3776;

   // Feature k sits at [16k+15:16k], matching the output port packing.
   typedef logic [NUM_FEAT-1:0][FEAT_W-1:0] feat_vec_t;

   // Bit offset of the source word for sensor3 feature k.
   function automatic int s3_word_lsb(input int k);
      if (k < 8)
         return RADAR_LSB + FEAT_W * k;
      else if (k < 12)
         return IMU_LSB + FEAT_W * (k - 8);
      else
         return TS_LSB + FEAT_W * (k - 12);
   endfunction

endpackage

`default_nettype wire

// File: rtl/adapter_sat16.sv
// +----------------------------------------------------------------------------+
// | adapter_sat16                                                              |
// | Clamps a 20-bit signed value into [lo, hi] and returns 16 bits + flag.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module adapter_sat16 (
   input  logic signed [19:0] din,
   input  logic signed [15:0] lo,
   input  logic signed [15:0] hi,
   output logic        [15:0] dout,
   output logic               clamped
);

   logic signed [19:0] w_lo_ext;
   logic signed [19:0] w_hi_ext;

   assign w_lo_ext = {{4{lo[15]}}, lo};
   assign w_hi_ext = {{4{hi[15]}}, hi};

   always_comb begin
      dout    = din[15:0];
      clamped = 1'b0;
      if (din < w_lo_ext) begin
         dout    = lo;
         clamped = 1'b1;
      end else if (din > w_hi_ext) begin
         dout    = hi;
         clamped = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/enhanced_data_adapter.sv
// +----------------------------------------------------------------------------+
// | enhanced_data_adapter                                                      |
// | Two-stage frame-to-feature reducer feeding the fusion core.                |
// | Optional sat_count output enabled by macro ADAPTER_SAT_COUNT_EN.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module enhanced_data_adapter
   import adapter_pkg::*;
#(
   parameter int FEAT_MIN  = -16384,
   parameter int FEAT_MAX  = 16383,
   parameter int CAM_SHIFT = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [FRAME_W-1:0]  temporal_aligned_data,
   input  logic                temporal_valid,
   output logic [255:0]        sensor1_features,
   output logic [255:0]        sensor2_features,
   output logic [255:0]        sensor3_features,
   output logic                features_valid,
`ifdef ADAPTER_SAT_COUNT_EN
   output logic                sat_flag,
   output logic [15:0]         sat_count
`else
   output logic                sat_flag
`endif
);

   localparam logic signed [FEAT_W-1:0] c_feat_min = FEAT_W'(FEAT_MIN);
   localparam logic signed [FEAT_W-1:0] c_feat_max = FEAT_W'(FEAT_MAX);

   logic [FRAME_W-1:0] r_frame;
   logic               r_v1;

   feat_vec_t          w_s1;
   feat_vec_t          w_s2;
   feat_vec_t          w_s3;
   logic [3*NUM_FEAT-1:0] w_clamp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame <= '0;
         r_v1    <= 1'b0;
      end else begin
         r_v1 <= temporal_valid;
         if (temporal_valid)
            r_frame <= temporal_aligned_data;
      end
   end

   for (genvar k = 0; k < NUM_FEAT; k++) begin : g_feat
      localparam int c_s3_lsb = s3_word_lsb(k);

      logic signed [SUM_W-1:0]  w_cam_sum;
      logic signed [SUM_W-1:0]  w_cam_pre;
      logic        [FEAT_W-1:0] w_lid_a;
      logic        [FEAT_W-1:0] w_lid_b;
      logic        [16:0]       w_lid_sum;
      logic signed [SUM_W-1:0]  w_lid_pre;
      logic        [FEAT_W-1:0] w_s3_word;
      logic signed [SUM_W-1:0]  w_s3_pre;

      always_comb begin
         logic [FEAT_W-1:0] v_word;
         w_cam_sum = '0;
         for (int j = 0; j < CAM_GROUP; j++) begin
            v_word    = r_frame[CAM_LSB + FEAT_W * (CAM_GROUP * k + j) +: FEAT_W];
            w_cam_sum = w_cam_sum + {{(SUM_W - FEAT_W){v_word[FEAT_W-1]}}, v_word};
         end
      end

      assign w_cam_pre = w_cam_sum >>> CAM_SHIFT;

      // Pair sum keeps 17 bits; dropping bit 0 is the arithmetic halving.
      assign w_lid_a   = r_frame[LIDAR_LSB + 2 * FEAT_W * k +: FEAT_W];
      assign w_lid_b   = r_frame[LIDAR_LSB + 2 * FEAT_W * k + FEAT_W +: FEAT_W];
      assign w_lid_sum = {w_lid_a[FEAT_W-1], w_lid_a} + {w_lid_b[FEAT_W-1], w_lid_b};
      assign w_lid_pre = {{4{w_lid_sum[16]}}, w_lid_sum[16:1]};

      assign w_s3_word = r_frame[c_s3_lsb +: FEAT_W];
      assign w_s3_pre  = {{(SUM_W - FEAT_W){w_s3_word[FEAT_W-1]}}, w_s3_word};

      adapter_sat16 u_sat_cam (
         .din     (w_cam_pre),
         .lo      (c_feat_min),
         .hi      (c_feat_max),
         .dout    (w_s1[k]),
         .clamped (w_clamp[k])
      );

      adapter_sat16 u_sat_lid (
         .din     (w_lid_pre),
         .lo      (c_feat_min),
         .hi      (c_feat_max),
         .dout    (w_s2[k]),
         .clamped (w_clamp[NUM_FEAT + k])
      );

      adapter_sat16 u_sat_s3 (
         .din     (w_s3_pre),
         .lo      (c_feat_min),
         .hi      (c_feat_max),
         .dout    (w_s3[k]),
         .clamped (w_clamp[2 * NUM_FEAT + k])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sensor1_features <= '0;
         sensor2_features <= '0;
         sensor3_features <= '0;
         features_valid   <= 1'b0;
         sat_flag         <= 1'b0;
      end else begin
         features_valid <= r_v1;
         if (r_v1) begin
            sensor1_features <= w_s1;
            sensor2_features <= w_s2;
            sensor3_features <= w_s3;
            sat_flag         <= |w_clamp;
         end
      end
   end

`ifdef ADAPTER_SAT_COUNT_EN
   logic [15:0] r_sat_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_sat_count <= '0;
      else if (features_valid && sat_flag && (r_sat_count != 16'hFFFF))
         r_sat_count <= r_sat_count + 16'd1;
   end

   assign sat_count = r_sat_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_enhanced_data_adapter.sv
// +----------------------------------------------------------------------------+
// | tb_enhanced_data_adapter                                                   |
// | Directed vector table, hand sequences and randomized model-checked stream. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_enhanced_data_adapter;

   logic          clk = 1'b0;
   logic          rst;
   logic [3839:0] temporal_aligned_data;
   logic          temporal_valid;
   logic [255:0]  sensor1_features;
   logic [255:0]  sensor2_features;
   logic [255:0]  sensor3_features;
   logic          features_valid;
   logic          sat_flag;
`ifdef ADAPTER_SAT_COUNT_EN
   logic [15:0]   sat_count;
`endif

   int total = 0;
   int bad   = 0;

   enhanced_data_adapter dut (
      .clk                   (clk),
      .rst                   (rst),
      .temporal_aligned_data (temporal_aligned_data),
      .temporal_valid        (temporal_valid),
      .sensor1_features      (sensor1_features),
      .sensor2_features      (sensor2_features),
      .sensor3_features      (sensor3_features),
      .features_valid        (features_valid),
`ifdef ADAPTER_SAT_COUNT_EN
      .sat_flag              (sat_flag),
      .sat_count             (sat_count)
`else
      .sat_flag              (sat_flag)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3839:0] frame;
      logic [255:0]  e1;
      logic [255:0]  e2;
      logic [255:0]  e3;
      logic          esat;
   } vec_t;

   vec_t tv[7];

   function automatic int wd(input logic [3839:0] f, input int lsb);
      logic [15:0] w;
      w = f[lsb +: 16];
      return int'($signed(w));
   endfunction

   function automatic int fdiv(input int a, input int d);
      int q;
      q = a / d;
      if ((a % d) != 0 && a < 0)
         q = q - 1;
      return q;
   endfunction

   function automatic logic [15:0] clampv(input int x, inout bit any);
      if (x < -16384) begin
         any = 1'b1;
         return 16'hC000;
      end
      if (x > 16383) begin
         any = 1'b1;
         return 16'h3FFF;
      end
      return 16'(x);
   endfunction

   // Reference: group sums, pair averages and direct words in plain integers.
   task automatic model(input logic [3839:0] f, output logic [255:0] e1,
                        output logic [255:0] e2, output logic [255:0] e3,
                        output logic es);
      bit any;
      int s;
      int src;
      any = 1'b0;
      for (int k = 0; k < 16; k++) begin
         s = 0;
         for (int j = 0; j < 12; j++)
            s += wd(f, 16 * (12 * k + j));
         e1[16*k +: 16] = clampv(fdiv(s, 8), any);
         s = wd(f, 3072 + 32 * k) + wd(f, 3072 + 32 * k + 16);
         e2[16*k +: 16] = clampv(fdiv(s, 2), any);
         if (k < 8)       src = 3584 + 16 * k;
         else if (k < 12) src = 3712 + 16 * (k - 8);
         else             src = 3776 + 16 * (k - 12);
         e3[16*k +: 16] = clampv(wd(f, src), any);
      end
      es = any;
   endtask

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic check_all(input string nm, input logic [255:0] e1, input logic [255:0] e2,
                            input logic [255:0] e3, input logic efv, input logic esat);
      chk({nm, " s1"}, sensor1_features, e1);
      chk({nm, " s2"}, sensor2_features, e2);
      chk({nm, " s3"}, sensor3_features, e3);
      chk({nm, " fv"}, {255'b0, features_valid}, {255'b0, efv});
      chk({nm, " sat"}, {255'b0, sat_flag}, {255'b0, esat});
   endtask

   function automatic logic [3839:0] rand_frame();
      logic [3839:0] f;
      int mode;
      for (int i = 0; i < 120; i++)
         f[32*i +: 32] = $urandom;
      mode = $urandom_range(0, 3);
      for (int w = 0; w < 240; w++) begin
         if (mode == 1 && w < 192)
            f[16*w +: 16] = 16'h6000 | 16'($urandom_range(0, 4095));
         else if (mode == 2 && w < 192)
            f[16*w +: 16] = 16'h9000 | 16'($urandom_range(0, 4095));
         else if (mode == 3)
            f[16*w +: 16] = 16'($urandom_range(0, 4000) - 2000);
      end
      return f;
   endfunction

   initial begin
      logic [3839:0] f;
      logic [255:0]  e;
      logic [255:0]  l1, l2, l3;
      logic          lsat;
      logic [255:0]  p1_1, p1_2, p1_3, p2_1, p2_2, p2_3;
      logic          p1_s, p2_s, p1_v, p2_v;

      // Directed vector table
      f = '0;
      for (int w = 0; w < 192; w++) f[16*w +: 16] = 16'd16;
      tv[0] = '{f, {16{16'h0018}}, '0, '0, 1'b0};

      f = '0;
      for (int w = 0; w < 32; w++) f[3072 + 16*w +: 16] = (w % 2 == 0) ? 16'd100 : 16'hFF9B;
      tv[1] = '{f, '0, {16{16'hFFFF}}, '0, 1'b0};

      f = '0;
      for (int w = 0; w < 32; w++) f[3072 + 16*w +: 16] = 16'd7;
      tv[2] = '{f, '0, {16{16'h0007}}, '0, 1'b0};

      f = '0;
      f[3584 +: 16] = 16'h7FFF;
      f[3712 +: 16] = 16'h8000;
      e = '0;
      e[15:0]    = 16'h3FFF;
      e[143:128] = 16'hC000;
      tv[3] = '{f, '0, '0, e, 1'b1};

      f = '0;
      for (int w = 0; w < 192; w++) f[16*w +: 16] = 16'h7FFF;
      tv[4] = '{f, {16{16'h3FFF}}, '0, '0, 1'b1};

      f = '0;
      for (int w = 0; w < 192; w++) f[16*w +: 16] = 16'h8000;
      tv[5] = '{f, {16{16'hC000}}, '0, '0, 1'b1};

      f = '0;
      f[3712 + 16 +: 16] = 16'hFFFB;
      for (int w = 0; w < 4; w++) f[3776 + 16*w +: 16] = 16'h1234;
      e = '0;
      e[16*9 +: 16] = 16'hFFFB;
      for (int k = 12; k < 16; k++) e[16*k +: 16] = 16'h1234;
      tv[6] = '{f, '0, '0, e, 1'b0};

      // Reset held while frames arrive
      rst = 1'b1;
      temporal_valid = 1'b0;
      temporal_aligned_data = '0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         temporal_aligned_data = rand_frame();
         temporal_valid = 1'b1;
         @(negedge clk);
         check_all("rst_hold", '0, '0, '0, 1'b0, 1'b0);
      end
      temporal_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      // Table: one frame at a time, strobe exactly two edges later
      for (int i = 0; i < 7; i++) begin
         temporal_aligned_data = tv[i].frame;
         temporal_valid = 1'b1;
         @(negedge clk);
         temporal_valid = 1'b0;
         chk($sformatf("vec%0d lat1 fv", i), {255'b0, features_valid}, 256'b0);
         @(negedge clk);
         check_all($sformatf("vec%0d", i), tv[i].e1, tv[i].e2, tv[i].e3, 1'b1, tv[i].esat);
         @(negedge clk);
         check_all($sformatf("vec%0d hold", i), tv[i].e1, tv[i].e2, tv[i].e3, 1'b0, tv[i].esat);
      end

      // Three back-to-back frames
      for (int i = 0; i < 3; i++) begin
         temporal_aligned_data = tv[i].frame;
         temporal_valid = 1'b1;
         @(negedge clk);
         if (i > 0)
            check_all($sformatf("b2b%0d", i - 1), tv[i-1].e1, tv[i-1].e2, tv[i-1].e3, 1'b1, tv[i-1].esat);
      end
      temporal_valid = 1'b0;
      @(negedge clk);
      check_all("b2b2", tv[2].e1, tv[2].e2, tv[2].e3, 1'b1, tv[2].esat);
      @(negedge clk);
      check_all("b2b hold", tv[2].e1, tv[2].e2, tv[2].e3, 1'b0, tv[2].esat);

      // Randomized stream against the reference model
      l1 = tv[2].e1; l2 = tv[2].e2; l3 = tv[2].e3; lsat = tv[2].esat;
      p1_v = 1'b0; p2_v = 1'b0;
      p1_1 = '0; p1_2 = '0; p1_3 = '0; p1_s = 1'b0;
      for (int cyc = 0; cyc < 80; cyc++) begin
         if (p2_v) begin
            l1 = p2_1; l2 = p2_2; l3 = p2_3; lsat = p2_s;
         end
         check_all("rnd", l1, l2, l3, p2_v, lsat);
         p2_v = p1_v; p2_1 = p1_1; p2_2 = p1_2; p2_3 = p1_3; p2_s = p1_s;
         p1_v = (cyc < 78) && ($urandom_range(0, 3) != 0);
         temporal_aligned_data = rand_frame();
         temporal_valid = p1_v;
         if (p1_v)
            model(temporal_aligned_data, p1_1, p1_2, p1_3, p1_s);
         @(negedge clk);
      end

      // Reset while a frame is in flight
      temporal_aligned_data = tv[3].frame;
      temporal_valid = 1'b1;
      @(negedge clk);
      temporal_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_all("mid_rst async", '0, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      check_all("mid_rst", '0, '0, '0, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check_all("post_rst1", '0, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      check_all("post_rst2", '0, '0, '0, 1'b0, 1'b0);

`ifdef ADAPTER_SAT_COUNT_EN
      chk("sat_count reset", {240'b0, sat_count}, 256'd0);
      temporal_aligned_data = tv[3].frame;
      temporal_valid = 1'b1;
      @(negedge clk);
      temporal_aligned_data = tv[4].frame;
      @(negedge clk);
      temporal_aligned_data = tv[0].frame;
      @(negedge clk);
      temporal_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("sat_count two", {240'b0, sat_count}, 256'd2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
